// File: rtl/mu_sequencer_if.sv
// Bus bundle between the microprogram sequencer and its environment:
// control-store port, dispatch-table write port, opcode, memory handshake and control fields.
interface mu_sequencer_if #(
    parameter int UADDR_W = 4,
    parameter int OP_W    = 6,
    parameter int TRANS_W = 3
);
    localparam int UW = 12 + TRANS_W;

    logic [UADDR_W-1:0] ucs_addr;
    logic [UW-1:0]      ucs_data;
    logic [OP_W-1:0]    opcode;
    logic               mem_ready;
    logic               disp_we;
    logic               disp_sel;
    logic [OP_W-1:0]    disp_idx;
    logic [UADDR_W-1:0] disp_data;
    logic               disp_vld;
    logic               PCWr;
    logic               PCWrCond;
    logic               IorD;
    logic               MemRd;
    logic               ALUSrcA;
    logic               RegWr;
    logic [TRANS_W-1:0] TransIn;
    logic [1:0]         ALUOp;
    logic [1:0]         ALUSrcB;
    logic [1:0]         Caddr;
    logic               stall;
    logic               illegal_op;

    modport master (
        output ucs_data, opcode, mem_ready, disp_we, disp_sel, disp_idx, disp_data, disp_vld,
        input  ucs_addr, PCWr, PCWrCond, IorD, MemRd, ALUSrcA, RegWr, TransIn, ALUOp,
               ALUSrcB, Caddr, stall, illegal_op
    );

    modport slave (
        input  ucs_data, opcode, mem_ready, disp_we, disp_sel, disp_idx, disp_data, disp_vld,
        output ucs_addr, PCWr, PCWrCond, IorD, MemRd, ALUSrcA, RegWr, TransIn, ALUOp,
               ALUSrcB, Caddr, stall, illegal_op
    );
endinterface

// File: rtl/mu_sequencer.sv
// Microprogram sequencer: micro-PC, micro-IR, two loadable opcode dispatch tables,
// memory-wait stalling and illegal-opcode detection.
module mu_sequencer #(
    parameter int UADDR_W = 4,
    parameter int OP_W    = 6,
    parameter int TRANS_W = 3
) (
    input  logic          clk,
    input  logic          rst,
    mu_sequencer_if.slave bus
);
    localparam int UW      = 12 + TRANS_W;
    localparam int DEPTH   = 2 ** OP_W;
    localparam int B_PCWR  = UW - 1;
    localparam int B_PCWRC = UW - 2;
    localparam int B_IORD  = UW - 3;
    localparam int B_MEMRD = UW - 4;

    typedef enum logic [1:0] {
        NXT_SEQ   = 2'd0,
        NXT_DISP1 = 2'd1,
        NXT_DISP2 = 2'd2,
        NXT_FETCH = 2'd3
    } next_sel_e;

    typedef struct packed {
        logic               vld;
        logic [UADDR_W-1:0] addr;
    } entry_t;

    logic [UADDR_W-1:0] upc_q, upc_d;
    logic [UW-1:0]      uir_q, uir_d;
    logic               illegal_q, illegal_d;
    entry_t             tbl1_q [DEPTH];
    entry_t             tbl1_d [DEPTH];
    entry_t             tbl2_q [DEPTH];
    entry_t             tbl2_d [DEPTH];
    entry_t             hit1, hit2;
    next_sel_e          next_sel;
    logic               stall;

    assign stall    = uir_q[B_MEMRD] & ~bus.mem_ready;
    assign next_sel = next_sel_e'(bus.ucs_data[1:0]);
    assign hit1     = tbl1_q[bus.opcode];
    assign hit2     = tbl2_q[bus.opcode];

    always_comb begin
        upc_d     = upc_q;
        uir_d     = uir_q;
        illegal_d = 1'b0;
        tbl1_d    = tbl1_q;
        tbl2_d    = tbl2_q;
        if (!stall) begin
            uir_d = bus.ucs_data;
            unique case (next_sel)
                NXT_SEQ:   upc_d = upc_q + 1'b1;
                NXT_DISP1: begin
                    upc_d     = hit1.vld ? hit1.addr : '0;
                    illegal_d = ~hit1.vld;
                end
                NXT_DISP2: begin
                    upc_d     = hit2.vld ? hit2.addr : '0;
                    illegal_d = ~hit2.vld;
                end
                NXT_FETCH: upc_d = '0;
            endcase
        end
        // Table lookups above read the _q copies, so a same-edge write is seen only next time.
        if (bus.disp_we) begin
            if (bus.disp_sel) tbl2_d[bus.disp_idx] = '{vld: bus.disp_vld, addr: bus.disp_data};
            else              tbl1_d[bus.disp_idx] = '{vld: bus.disp_vld, addr: bus.disp_data};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            upc_q     <= '0;
            uir_q     <= '0;
            illegal_q <= 1'b0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                tbl1_q[i] <= '0;
                tbl2_q[i] <= '0;
            end
        end else begin
            upc_q     <= upc_d;
            uir_q     <= uir_d;
            illegal_q <= illegal_d;
            tbl1_q    <= tbl1_d;
            tbl2_q    <= tbl2_d;
        end
    end

    // Write enables are squashed while waiting on memory; everything else holds from uir.
    assign bus.ucs_addr   = upc_q;
    assign bus.PCWr       = uir_q[B_PCWR] & ~stall;
    assign bus.PCWrCond   = uir_q[B_PCWRC] & ~stall;
    assign bus.IorD       = uir_q[B_IORD];
    assign bus.MemRd      = uir_q[B_MEMRD];
    assign bus.TransIn    = uir_q[8 +: TRANS_W];
    assign bus.ALUOp      = uir_q[7:6];
    assign bus.ALUSrcB    = uir_q[5:4];
    assign bus.ALUSrcA    = uir_q[3];
    assign bus.RegWr      = uir_q[2] & ~stall;
    assign bus.Caddr      = uir_q[1:0];
    assign bus.stall      = stall;
    assign bus.illegal_op = illegal_q;
endmodule

// File: tb/tb_mu_sequencer.sv
// Directed bench for mu_sequencer: abstract cycle model plus per-cycle output compare
// and hand-computed literal checks for reset, wrap, dispatch, illegal, stall and collision.
module tb_mu_sequencer;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    mu_sequencer_if #(.UADDR_W(4), .OP_W(6), .TRANS_W(3)) bus();
    mu_sequencer #(.UADDR_W(4), .OP_W(6), .TRANS_W(3)) dut (.clk(clk), .rst(rst), .bus(bus));

    logic [14:0] ucs_mem [16];
    always_comb bus.ucs_data = ucs_mem[bus.ucs_addr];

    int total = 0;
    int bad = 0;
    bit chk_en = 1'b0;

    int m_upc, m_uir, m_ill;
    int m_vld1 [64];
    int m_adr1 [64];
    int m_vld2 [64];
    int m_adr2 [64];

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int fld(int w, int lo, int n);
        return (w >> lo) & ((1 << n) - 1);
    endfunction

    function automatic logic [14:0] mk(int pcwr, int pcwrc, int iord, int memrd, int trans,
                                       int aluop, int srcb, int srca, int regwr, int caddr);
        return 15'(pcwr * 16384 + pcwrc * 8192 + iord * 4096 + memrd * 2048 + trans * 256 +
                   aluop * 64 + srcb * 16 + srca * 8 + regwr * 4 + caddr);
    endfunction

    task automatic model_reset();
        m_upc = 0; m_uir = 0; m_ill = 0;
        for (int i = 0; i < 64; i++) begin
            m_vld1[i] = 0; m_adr1[i] = 0; m_vld2[i] = 0; m_adr2[i] = 0;
        end
    endtask

    task automatic model_step();
        int w, nu, nill, op, waiting;
        w = int'(ucs_mem[m_upc]);
        waiting = fld(m_uir, 11, 1) & (bus.mem_ready ? 0 : 1);
        nill = 0;
        if (waiting == 0) begin
            op = int'(bus.opcode);
            nu = 0;
            case (w % 4)
                0: nu = (m_upc + 1) % 16;
                1: if (m_vld1[op] != 0) nu = m_adr1[op]; else nill = 1;
                2: if (m_vld2[op] != 0) nu = m_adr2[op]; else nill = 1;
                default: nu = 0;
            endcase
            m_uir = w;
            m_upc = nu;
        end
        m_ill = nill;
        if (bus.disp_we) begin
            if (bus.disp_sel) begin
                m_vld2[int'(bus.disp_idx)] = int'(bus.disp_vld);
                m_adr2[int'(bus.disp_idx)] = int'(bus.disp_data);
            end else begin
                m_vld1[int'(bus.disp_idx)] = int'(bus.disp_vld);
                m_adr1[int'(bus.disp_idx)] = int'(bus.disp_data);
            end
        end
    endtask

    function automatic logic [31:0] exp_vec();
        int st, g, e;
        st = fld(m_uir, 11, 1) & (bus.mem_ready ? 0 : 1);
        g = 1 - st;
        e = m_upc;
        e = (e << 1) | (fld(m_uir, 14, 1) & g);
        e = (e << 1) | (fld(m_uir, 13, 1) & g);
        e = (e << 1) | fld(m_uir, 12, 1);
        e = (e << 1) | fld(m_uir, 11, 1);
        e = (e << 3) | fld(m_uir, 8, 3);
        e = (e << 2) | fld(m_uir, 6, 2);
        e = (e << 2) | fld(m_uir, 4, 2);
        e = (e << 1) | fld(m_uir, 3, 1);
        e = (e << 1) | (fld(m_uir, 2, 1) & g);
        e = (e << 1) | st;
        e = (e << 1) | m_ill;
        return 32'(e);
    endfunction

    function automatic logic [31:0] act_vec();
        return {13'd0, bus.ucs_addr, bus.PCWr, bus.PCWrCond, bus.IorD, bus.MemRd, bus.TransIn,
                bus.ALUOp, bus.ALUSrcB, bus.ALUSrcA, bus.RegWr, bus.stall, bus.illegal_op};
    endfunction

    always @(posedge clk) if (!rst) model_step();

    always @(negedge clk) if (chk_en) check("outputs", act_vec(), exp_vec());

    task automatic cyc();
        @(negedge clk);
        #2;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        model_reset();
        cyc();
        rst = 1'b0;
    endtask

    task automatic fill_plain();
        for (int a = 0; a < 16; a++) ucs_mem[a] = mk(0, 0, 0, 0, a % 8, a % 4, (a / 4) % 4, a % 2, 0, 0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bus.opcode = '0; bus.mem_ready = 1'b1; bus.disp_we = 1'b0; bus.disp_sel = 1'b0;
        bus.disp_idx = '0; bus.disp_data = '0; bus.disp_vld = 1'b0;
        for (int a = 0; a < 16; a++) ucs_mem[a] = 15'($urandom);
        model_reset();
        chk_en = 1'b1;

        // Reset with random microwords, then first edge loads word 0
        cyc(); cyc();
        check("rst_addr", 32'(bus.ucs_addr), 32'd0);
        check("rst_ctl", act_vec(), 32'd0);
        ucs_mem[0] = mk(0, 1, 1, 0, 5, 2, 1, 1, 0, 0);
        rst = 1'b0;
        cyc();
        check("first_trans", 32'(bus.TransIn), 32'd5);
        check("first_addr", 32'(bus.ucs_addr), 32'd1);

        // Sequential walk with wrap
        fill_plain();
        do_reset();
        for (int k = 1; k <= 17; k++) begin
            cyc();
            check("seq_addr", 32'(bus.ucs_addr), 32'(k % 16));
            check("seq_trans", 32'(bus.TransIn), 32'(((k - 1) % 16) % 8));
        end

        // Dispatch through tbl1 then tbl2
        fill_plain();
        ucs_mem[1] = mk(0, 0, 0, 0, 1, 0, 0, 0, 0, 1);
        ucs_mem[6] = mk(1, 0, 0, 0, 6, 1, 2, 0, 1, 2);
        ucs_mem[9] = mk(0, 0, 1, 0, 2, 3, 3, 1, 0, 3);
        do_reset();
        bus.opcode = 6'h23;
        bus.disp_we = 1'b1; bus.disp_sel = 1'b0; bus.disp_idx = 6'h23;
        bus.disp_data = 4'h6; bus.disp_vld = 1'b1;
        cyc();
        bus.disp_sel = 1'b1; bus.disp_data = 4'h9;
        cyc();
        bus.disp_we = 1'b0;
        check("disp1_addr", 32'(bus.ucs_addr), 32'd6);
        check("disp1_ill", 32'(bus.illegal_op), 32'd0);
        cyc();
        check("disp2_addr", 32'(bus.ucs_addr), 32'd9);
        check("disp2_ill", 32'(bus.illegal_op), 32'd0);
        cyc();
        check("fetch_addr", 32'(bus.ucs_addr), 32'd0);

        // Illegal opcode
        bus.opcode = 6'h3F;
        cyc();
        check("ill_pre_addr", 32'(bus.ucs_addr), 32'd1);
        cyc();
        check("ill_addr", 32'(bus.ucs_addr), 32'd0);
        check("ill_pulse", 32'(bus.illegal_op), 32'd1);
        cyc();
        check("ill_clear", 32'(bus.illegal_op), 32'd0);

        // Memory-wait stall
        fill_plain();
        ucs_mem[1] = mk(1, 0, 0, 1, 3, 0, 0, 0, 1, 0);
        ucs_mem[2] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 3);
        do_reset();
        cyc();
        bus.mem_ready = 1'b0;
        cyc();
        for (int k = 0; k < 3; k++) begin
            check("stall_flag", 32'(bus.stall), 32'd1);
            check("stall_wr", {30'd0, bus.PCWr, bus.RegWr}, 32'd0);
            check("stall_hold", {24'd0, bus.ucs_addr, bus.MemRd, bus.TransIn}, 32'h2B);
            if (k < 2) cyc();
        end
        bus.mem_ready = 1'b1;
        #1;
        check("release_wr", {29'd0, bus.stall, bus.PCWr, bus.RegWr}, 32'd3);
        cyc();
        check("advance_addr", 32'(bus.ucs_addr), 32'd0);
        check("advance_wr", {30'd0, bus.PCWr, bus.MemRd}, 32'd0);

        // Reset asserted mid-stall
        do_reset();
        cyc();
        bus.mem_ready = 1'b0;
        cyc();
        check("mid_stall", 32'(bus.stall), 32'd1);
        #1;
        rst = 1'b1;
        model_reset();
        #1;
        check("rst_mid_stall", act_vec(), 32'd0);
        cyc();
        rst = 1'b0;
        bus.mem_ready = 1'b1;
        cyc();
        check("rst_recover", 32'(bus.ucs_addr), 32'd1);

        // Same-edge write/read collision on tbl1[5]
        fill_plain();
        ucs_mem[1] = mk(0, 0, 0, 0, 1, 0, 0, 0, 0, 1);
        ucs_mem[3] = mk(0, 0, 0, 0, 3, 0, 0, 0, 0, 3);
        ucs_mem[10] = mk(0, 0, 0, 0, 2, 0, 0, 0, 0, 3);
        do_reset();
        bus.opcode = 6'h05;
        bus.disp_we = 1'b1; bus.disp_sel = 1'b0; bus.disp_idx = 6'h05;
        bus.disp_data = 4'h3; bus.disp_vld = 1'b1;
        cyc();
        bus.disp_data = 4'hA;
        cyc();
        bus.disp_we = 1'b0;
        check("coll_old", 32'(bus.ucs_addr), 32'd3);
        cyc(); cyc(); cyc();
        check("coll_new", 32'(bus.ucs_addr), 32'hA);
        cyc();

        chk_en = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
